// File: rtl/xevious_input_ctrl_if.sv
// ----------------------------------------------------------------------------
// xevious_input_ctrl_if
// Bundles the raw player inputs and the shaped control outputs of the Xevious
// input controller.
//   ps2_key     [64] event toggle, [15:8] 0xF0 on release / 0xE0 extended,
//               [23:16] 0xE0 on extended release, [7:0] scan code,
//               [63:24] nonzero for PRNSCR/PAUSE
//   joystick_0/1  bit 0 right, 1 left, 2 down, 3 up, 4 fire, 5 bomb,
//               6 start1, 7 start2, 8 coin
//   rotate      1 = horizontal-screen remap of the directions
//   up..start2  registered active-high controls
//   coin        registered, shaped coin pulse
// master: the side that drives the raw inputs (board glue / testbench).
// slave:  the controller itself.
// ----------------------------------------------------------------------------
interface xevious_input_ctrl_if;
    logic [64:0] ps2_key;
    logic [15:0] joystick_0;
    logic [15:0] joystick_1;
    logic        rotate;
    logic        up;
    logic        down;
    logic        left;
    logic        right;
    logic        fire;
    logic        bomb;
    logic        start1;
    logic        start2;
    logic        coin;

    modport master (
        output ps2_key, joystick_0, joystick_1, rotate,
        input  up, down, left, right, fire, bomb, start1, start2, coin
    );

    modport slave (
        input  ps2_key, joystick_0, joystick_1, rotate,
        output up, down, left, right, fire, bomb, start1, start2, coin
    );
endinterface

// File: rtl/xevious_input_ctrl.sv
// ----------------------------------------------------------------------------
// xevious_input_ctrl
// Merges PS/2 keyboard events and two joysticks into the Xevious control
// set, optionally remapping directions for a rotated screen, and shapes any
// start/coin request into a single coin pulse of fixed width followed by a
// dead time.
// Ports:
//   clk_sys  system clock, all logic on its rising edge
//   reset_n  asynchronous active-low reset
//   bus      xevious_input_ctrl_if.slave (raw inputs in, controls out)
// Parameters:
//   COIN_LEN  coin pulse width in clk_sys cycles
//   COIN_GAP  dead time after a coin pulse in clk_sys cycles
// ----------------------------------------------------------------------------
module xevious_input_ctrl #(
    parameter int COIN_LEN = 1800000,
    parameter int COIN_GAP = 1800000
) (
    input logic                  clk_sys,
    input logic                  reset_n,
    xevious_input_ctrl_if.slave  bus
);

    localparam int CNT_MAX = (COIN_LEN > COIN_GAP) ? COIN_LEN : COIN_GAP;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] LEN_LOAD = CNT_W'(COIN_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(COIN_GAP - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } coin_state_t;

    // ------------------------------------------------------------------
    // Keyboard event decode
    // ------------------------------------------------------------------
    logic       old_toggle;
    logic       first_cycle;
    logic       pressed;
    logic       ext;
    logic [8:0] code;
    logic       key_event;

    // NOTE: every signal assigned in always_comb gets a value on every path;
    // a missing assignment would infer a latch.
    always_comb begin
        pressed   = (bus.ps2_key[15:8] != 8'hF0);
        ext       = pressed ? (bus.ps2_key[15:8]  == 8'hE0)
                            : (bus.ps2_key[23:16] == 8'hE0);
        code      = {ext, bus.ps2_key[7:0]};
        // PRNSCR/PAUSE sequences carry extra bytes; treat them as no key.
        if (|bus.ps2_key[63:24]) begin
            code = 9'h000;
        end
        // The first edge after reset only primes old_toggle, so a toggle
        // level left over from before reset is not mistaken for an event.
        key_event = !first_cycle && (bus.ps2_key[64] != old_toggle);
    end

    logic kb_up, kb_down, kb_left, kb_right;
    logic kb_fire, kb_bomb, kb_start1, kb_start2, kb_coin;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    // NOTE: this block holds only a handful of flops, so all of them get the
    // asynchronous reset; there is no storage array that would need to skip it.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            old_toggle  <= 1'b0;
            first_cycle <= 1'b1;
            kb_up       <= 1'b0;
            kb_down     <= 1'b0;
            kb_left     <= 1'b0;
            kb_right    <= 1'b0;
            kb_fire     <= 1'b0;
            kb_bomb     <= 1'b0;
            kb_start1   <= 1'b0;
            kb_start2   <= 1'b0;
            kb_coin     <= 1'b0;
        end else begin
            old_toggle  <= bus.ps2_key[64];
            first_cycle <= 1'b0;
            if (key_event) begin
                // Cursor keys and Ctrl exist in both plain and E0 forms;
                // the remaining keys only match their plain form.
                case (code[7:0])
                    8'h75:   kb_up    <= pressed;
                    8'h72:   kb_down  <= pressed;
                    8'h6B:   kb_left  <= pressed;
                    8'h74:   kb_right <= pressed;
                    8'h14:   kb_bomb  <= pressed;
                    8'h29:   if (!code[8]) kb_fire   <= pressed;
                    8'h05:   if (!code[8]) kb_start1 <= pressed;
                    8'h06:   if (!code[8]) kb_start2 <= pressed;
                    8'h2E:   if (!code[8]) kb_coin   <= pressed;
                    default: ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Control merge and screen-rotation remap
    // ------------------------------------------------------------------
    logic [15:0] joy;
    logic        phys_up, phys_down, phys_left, phys_right;
    logic        up_i, down_i, left_i, right_i;
    logic        fire_i, bomb_i, start1_i, start2_i;
    logic        coin_req;
    logic        unused_joy;

    always_comb begin
        joy        = bus.joystick_0 | bus.joystick_1;
        phys_up    = kb_up    | joy[3];
        phys_down  = kb_down  | joy[2];
        phys_left  = kb_left  | joy[1];
        phys_right = kb_right | joy[0];
        if (bus.rotate) begin
            up_i    = phys_left;
            down_i  = phys_right;
            left_i  = phys_down;
            right_i = phys_up;
        end else begin
            up_i    = phys_up;
            down_i  = phys_down;
            left_i  = phys_left;
            right_i = phys_right;
        end
        fire_i   = kb_fire   | joy[4];
        bomb_i   = kb_bomb   | joy[5];
        start1_i = kb_start1 | joy[6];
        start2_i = kb_start2 | joy[7];
        // Pressing start also drops a coin, so a single key starts a game.
        coin_req = start1_i | start2_i | kb_coin | joy[8];
    end

    assign unused_joy = ^joy[15:9];

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            bus.up     <= 1'b0;
            bus.down   <= 1'b0;
            bus.left   <= 1'b0;
            bus.right  <= 1'b0;
            bus.fire   <= 1'b0;
            bus.bomb   <= 1'b0;
            bus.start1 <= 1'b0;
            bus.start2 <= 1'b0;
        end else begin
            bus.up     <= up_i;
            bus.down   <= down_i;
            bus.left   <= left_i;
            bus.right  <= right_i;
            bus.fire   <= fire_i;
            bus.bomb   <= bomb_i;
            bus.start1 <= start1_i;
            bus.start2 <= start2_i;
        end
    end

    // ------------------------------------------------------------------
    // Coin pulse shaper
    // ------------------------------------------------------------------
    coin_state_t      coin_state;
    logic [CNT_W-1:0] coin_cnt;
    logic             coin_req_d;

    // coin_req_d resets high so a request already held when reset releases
    // does not look like a fresh rising edge.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            coin_state <= IDLE;
            coin_cnt   <= '0;
            coin_req_d <= 1'b1;
            bus.coin   <= 1'b0;
        end else begin
            coin_req_d <= coin_req;
            case (coin_state)
                IDLE: begin
                    // Only a fresh edge starts a pulse; edges seen in
                    // PULSE/GAP are dropped and a held level never retriggers.
                    if (coin_req && !coin_req_d) begin
                        coin_cnt   <= LEN_LOAD;
                        coin_state <= PULSE;
                        bus.coin   <= 1'b1;
                    end
                end
                PULSE: begin
                    if (coin_cnt == '0) begin
                        coin_cnt   <= GAP_LOAD;
                        coin_state <= GAP;
                        bus.coin   <= 1'b0;
                    end else begin
                        coin_cnt <= coin_cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (coin_cnt == '0) begin
                        coin_state <= IDLE;
                    end else begin
                        coin_cnt <= coin_cnt - 1'b1;
                    end
                end
                default: begin
                    coin_state <= IDLE;
                    coin_cnt   <= '0;
                    bus.coin   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xevious_input_ctrl.sv
// ----------------------------------------------------------------------------
// tb_xevious_input_ctrl
// Directed scenarios followed by randomized keyboard/joystick/rotate traffic.
// A behavioural model tracks which keys are held, the rotation mapping and the
// coin pulse as "cycle the current pulse started", and predicts all nine
// outputs after every clock edge.
// ----------------------------------------------------------------------------
module tb_xevious_input_ctrl;

    localparam int LEN = 4;
    localparam int GAP = 3;

    localparam int K_UP    = 0;
    localparam int K_DOWN  = 1;
    localparam int K_LEFT  = 2;
    localparam int K_RIGHT = 3;
    localparam int K_FIRE  = 4;
    localparam int K_BOMB  = 5;
    localparam int K_S1    = 6;
    localparam int K_S2    = 7;
    localparam int K_COIN  = 8;

    logic clk = 1'b0;
    logic reset_n;

    xevious_input_ctrl_if bus ();

    xevious_input_ctrl #(
        .COIN_LEN (LEN),
        .COIN_GAP (GAP)
    ) dut (
        .clk_sys (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;
    int coin_high  = 0;

    // ---------------- reference model state ----------------
    bit m_kb [9];
    bit m_old_tog;
    bit m_first;
    bit m_prev_req;
    int m_edge  = 0;
    int m_start = -1000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (m_kb[i]) m_kb[i] = 1'b0;
        m_old_tog  = 1'b0;
        m_first    = 1'b1;
        m_prev_req = 1'b1;
        m_start    = m_edge - 1000;
    endtask

    function automatic int key_index(input logic [7:0] sc, input bit ext);
        case (sc)
            8'h75:   return K_UP;
            8'h72:   return K_DOWN;
            8'h6B:   return K_LEFT;
            8'h74:   return K_RIGHT;
            8'h14:   return K_BOMB;
            8'h29:   return ext ? -1 : K_FIRE;
            8'h05:   return ext ? -1 : K_S1;
            8'h06:   return ext ? -1 : K_S2;
            8'h2E:   return ext ? -1 : K_COIN;
            default: return -1;
        endcase
    endfunction

    // Predict the outputs after the coming edge, advance the model, apply the
    // edge and compare.
    task automatic step();
        logic [15:0] joy;
        bit p_u, p_d, p_l, p_r;
        bit e_u, e_d, e_l, e_r;
        bit req, coin_e, rel, ext;
        int idx;
        logic [8:0] exp_v, got_v;

        joy = bus.joystick_0 | bus.joystick_1;
        p_u = m_kb[K_UP]    | joy[3];
        p_d = m_kb[K_DOWN]  | joy[2];
        p_l = m_kb[K_LEFT]  | joy[1];
        p_r = m_kb[K_RIGHT] | joy[0];
        if (bus.rotate) begin
            e_u = p_l; e_d = p_r; e_l = p_d; e_r = p_u;
        end else begin
            e_u = p_u; e_d = p_d; e_l = p_l; e_r = p_r;
        end
        req = m_kb[K_S1] | joy[6] | m_kb[K_S2] | joy[7] | m_kb[K_COIN] | joy[8];
        // A pulse is accepted on a rising request once the previous pulse
        // (LEN cycles), its gap (GAP cycles) and the return edge to idle are over.
        if (req && !m_prev_req && (m_edge - m_start >= LEN + GAP + 1))
            m_start = m_edge;
        m_prev_req = req;
        coin_e = (m_edge - m_start) < LEN;
        exp_v = {e_u, e_d, e_l, e_r,
                 m_kb[K_FIRE] | joy[4], m_kb[K_BOMB] | joy[5],
                 m_kb[K_S1] | joy[6], m_kb[K_S2] | joy[7], coin_e};

        if (!m_first && (bus.ps2_key[64] != m_old_tog) && (bus.ps2_key[63:24] == 40'd0)) begin
            rel = (bus.ps2_key[15:8] == 8'hF0);
            ext = rel ? (bus.ps2_key[23:16] == 8'hE0) : (bus.ps2_key[15:8] == 8'hE0);
            idx = key_index(bus.ps2_key[7:0], ext);
            if (idx >= 0) m_kb[idx] = !rel;
        end
        m_old_tog = bus.ps2_key[64];
        m_first   = 1'b0;
        m_edge++;

        @(posedge clk);
        #1;
        got_v = {bus.up, bus.down, bus.left, bus.right, bus.fire, bus.bomb,
                 bus.start1, bus.start2, bus.coin};
        check("outs", got_v, exp_v);
        if (bus.coin) coin_high++;
    endtask

    task automatic send_key(input logic [7:0] sc, input bit rel, input bit ext, input bit prn);
        logic [64:0] k;
        k        = '0;
        k[64]    = ~bus.ps2_key[64];
        k[63:24] = prn ? {8'h00, $urandom() | 32'h1} : 40'd0;
        k[23:16] = (rel && ext) ? 8'hE0 : 8'h00;
        k[15:8]  = rel ? 8'hF0 : (ext ? 8'hE0 : 8'h00);
        k[7:0]   = sc;
        bus.ps2_key = k;
        step();
    endtask

    logic [7:0] codes [12] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h14, 8'h29,
                               8'h05, 8'h06, 8'h2E, 8'h1C, 8'h00, 8'h5A};

    initial begin
        // Reset with a stale "space" toggle already on the bus.
        reset_n        = 1'b0;
        bus.ps2_key    = '0;
        bus.ps2_key[64] = 1'b1;
        bus.ps2_key[7:0] = 8'h29;
        bus.joystick_0 = '0;
        bus.joystick_1 = '0;
        bus.rotate     = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs",
              {bus.up, bus.down, bus.left, bus.right, bus.fire, bus.bomb,
               bus.start1, bus.start2, bus.coin}, 9'h000);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) step();
        check("fire_after_reset", bus.fire, 1'b0);

        // Up key press and release, two-edge latency.
        send_key(8'h75, 1'b0, 1'b0, 1'b0);
        check("up_one_edge", bus.up, 1'b0);
        step();
        check("up_press", bus.up, 1'b1);
        send_key(8'h75, 1'b1, 1'b0, 1'b0);
        step();
        check("up_release", bus.up, 1'b0);

        // Rotation remap of a held key, then joystick.
        send_key(8'h75, 1'b0, 1'b0, 1'b0);
        step();
        bus.rotate = 1'b1;
        step();
        check("rot_up", bus.up, 1'b0);
        check("rot_right", bus.right, 1'b1);
        bus.joystick_1[1] = 1'b1;
        step();
        check("rot_joy_up", bus.up, 1'b1);
        bus.joystick_1 = '0;
        bus.rotate     = 1'b0;
        send_key(8'h75, 1'b1, 1'b0, 1'b0);
        step();

        // PRNSCR-style event must be ignored.
        send_key(8'h75, 1'b0, 1'b0, 1'b1);
        repeat (2) step();
        check("prnscr_ignored", bus.up, 1'b0);

        // Back-to-back press and release of different keys.
        send_key(8'h72, 1'b0, 1'b0, 1'b0);
        send_key(8'h6B, 1'b0, 1'b1, 1'b0);
        send_key(8'h72, 1'b1, 1'b0, 1'b0);
        step();
        check("b2b_down", bus.down, 1'b0);
        check("b2b_left", bus.left, 1'b1);
        send_key(8'h6B, 1'b1, 1'b1, 1'b0);
        step();

        // F1 coin pulse; F2 edge inside the pulse is dropped.
        send_key(8'h05, 1'b0, 1'b0, 1'b0);
        coin_high = 0;
        step();
        check("start1_f1", bus.start1, 1'b1);
        check("coin_rise", bus.coin, 1'b1);
        send_key(8'h05, 1'b1, 1'b0, 1'b0);
        send_key(8'h06, 1'b0, 1'b0, 1'b0);
        repeat (10) step();
        check("coin_width", coin_high, 4);
        send_key(8'h06, 1'b1, 1'b0, 1'b0);
        step();
        coin_high = 0;
        send_key(8'h06, 1'b0, 1'b0, 1'b0);
        repeat (10) step();
        check("coin_width2", coin_high, 4);
        send_key(8'h06, 1'b1, 1'b0, 1'b0);
        repeat (10) step();

        // Reset during the second pulse cycle, request held through release.
        bus.joystick_0[6] = 1'b1;
        step();
        step();
        check("coin_cycle2", bus.coin, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("coin_async_rst", bus.coin, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        coin_high = 0;
        repeat (12) step();
        check("held_no_retrigger", coin_high, 0);
        bus.joystick_0[6] = 1'b0;
        step();
        bus.joystick_0[6] = 1'b1;
        step();
        check("repress_coin", bus.coin, 1'b1);
        bus.joystick_0[6] = 1'b0;
        repeat (10) step();

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.joystick_0 = 16'($urandom()) & 16'($urandom()) & 16'($urandom());
                bus.joystick_1 = 16'($urandom()) & 16'($urandom()) & 16'($urandom());
            end
            if ($urandom_range(0, 15) == 0) bus.rotate = ~bus.rotate;
            if ($urandom_range(0, 9) == 0) begin
                bus.joystick_0 = '0;
                bus.joystick_1 = '0;
            end
            if ($urandom_range(0, 2) == 0)
                send_key(codes[$urandom_range(0, 11)], 1'($urandom_range(0, 1)),
                         $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
            else
                step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
